// File: rtl/channel_output_compare_pkg.sv
// Shared encodings for the advtim channel-1 output-compare slice: compare modes,
// dead-time FSM state codes and the reference-waveform update rule.
package channel_output_compare_pkg;

   localparam int unsigned CW_DEF  = 16;
   localparam int unsigned DTW_DEF = 8;

   localparam logic [2:0] OCM_FROZEN   = 3'b000;
   localparam logic [2:0] OCM_PWM      = 3'b001;
   localparam logic [2:0] OCM_TOGGLE   = 3'b010;
   localparam logic [2:0] OCM_FORCE_LO = 3'b011;
   localparam logic [2:0] OCM_FORCE_HI = 3'b100;

   localparam logic [2:0] DT_IDLE = 3'd0;
   localparam logic [2:0] DT_P_ON = 3'd1;
   localparam logic [2:0] DT_N_ON = 3'd2;
   localparam logic [2:0] DT_DT_P = 3'd3;
   localparam logic [2:0] DT_DT_N = 3'd4;

   // Next oc1ref value; in pwm a coincident last hit wins, toggle inverts once.
   function automatic logic oc_next_ref(input logic [2:0] mode, input logic cur,
                                        input logic first_hit, input logic last_hit);
      case (mode)
         OCM_PWM:      return last_hit ? 1'b0 : (first_hit ? 1'b1 : cur);
         OCM_TOGGLE:   return (first_hit | last_hit) ? ~cur : cur;
         OCM_FORCE_LO: return 1'b0;
         OCM_FORCE_HI: return 1'b1;
         default:      return cur;
      endcase
   endfunction

endpackage

// File: rtl/channel_output_compare_deadtime_gen.sv
// Complementary output driver for oc1ref with programmable dead time between
// the main (oc1p) and complementary (oc1n) phases.
module channel_deadtime_gen
   import channel_output_compare_pkg::*;
#(
   parameter int unsigned DTW = DTW_DEF
) (
   input  logic           pe_cap_clk,
   input  logic           pe_cap_rstn,
   input  logic           clr,
   input  logic           timing_enable,
   input  logic           oc1ref,
   input  logic [DTW-1:0] r_dtg,
   input  logic           r_oc1ne,
   output logic           oc1p,
   output logic           oc1n
);

   logic [2:0]     state, state_nxt;
   logic [DTW-1:0] dt_cnt, dt_nxt;
   logic [DTW-1:0] dt_load;
   logic           dtg_zero;

   assign dt_load  = r_dtg - DTW'(1);
   assign dtg_zero = (r_dtg == '0);

   // A reference change during a dead-time gap restarts the gap toward the new side.
   always_comb begin
      state_nxt = state;
      dt_nxt    = dt_cnt;
      if (!timing_enable) begin
         state_nxt = DT_IDLE;
         dt_nxt    = '0;
      end else begin
         case (state)
            DT_IDLE: state_nxt = oc1ref ? DT_P_ON : DT_N_ON;
            DT_N_ON, DT_DT_N: begin
               if (oc1ref) begin
                  state_nxt = dtg_zero ? DT_P_ON : DT_DT_P;
                  dt_nxt    = dt_load;
               end else if (state == DT_DT_N) begin
                  if (dt_cnt == '0) state_nxt = DT_N_ON;
                  else              dt_nxt    = dt_cnt - DTW'(1);
               end
            end
            DT_P_ON, DT_DT_P: begin
               if (!oc1ref) begin
                  state_nxt = dtg_zero ? DT_N_ON : DT_DT_N;
                  dt_nxt    = dt_load;
               end else if (state == DT_DT_P) begin
                  if (dt_cnt == '0) state_nxt = DT_P_ON;
                  else              dt_nxt    = dt_cnt - DTW'(1);
               end
            end
            default: begin
               state_nxt = DT_IDLE;
               dt_nxt    = '0;
            end
         endcase
      end
   end

   always_ff @(posedge pe_cap_clk or negedge pe_cap_rstn) begin
      if (!pe_cap_rstn) begin
         state  <= DT_IDLE;
         dt_cnt <= '0;
      end else if (clr) begin
         state  <= DT_IDLE;
         dt_cnt <= '0;
      end else begin
         state  <= state_nxt;
         dt_cnt <= dt_nxt;
      end
   end

   assign oc1p = (state == DT_P_ON);
   assign oc1n = (state == DT_N_ON) & r_oc1ne;

endmodule

// File: rtl/channel_output_compare.sv
// Channel-1 output compare: compare-register shadows, first/last match against
// the shared counters, oc1ref generation and the complementary output stage.
module channel_output_compare
   import channel_output_compare_pkg::*;
#(
   parameter int unsigned CW  = CW_DEF,
   parameter int unsigned DTW = DTW_DEF
) (
   input  logic           pe_cap_clk,
   input  logic           pe_cap_rstn,
   input  logic           pe_cap_logic_clr,
   input  logic           timing_enable,
   input  logic [CW-1:0]  arr_cnt,
   input  logic [CW-1:0]  rcr_cnt,
   input  logic           update_evt,
   input  logic [2:0]     r_oc1m,
   input  logic           r_oc1pe,
   input  logic           r_oc1ne,
   input  logic [CW-1:0]  r_ofc,
   input  logic [CW-1:0]  r_olc,
   input  logic [CW-1:0]  r_ofr,
   input  logic [CW-1:0]  r_olr,
   input  logic [DTW-1:0] r_dtg,
   output logic           oc1ref,
   output logic           oc1p,
   output logic           oc1n,
   output logic           oc1_first_match,
   output logic           oc1_last_match
);

   logic [CW-1:0] ofc_sh, olc_sh, ofr_sh, olr_sh;
   logic          first_hit, last_hit;

   // Matches in an update cycle still see the old shadow values.
   always_ff @(posedge pe_cap_clk or negedge pe_cap_rstn) begin
      if (!pe_cap_rstn) begin
         ofc_sh <= '0;
         olc_sh <= '0;
         ofr_sh <= '0;
         olr_sh <= '0;
      end else if (pe_cap_logic_clr) begin
         ofc_sh <= '0;
         olc_sh <= '0;
         ofr_sh <= '0;
         olr_sh <= '0;
      end else if (!r_oc1pe || update_evt) begin
         ofc_sh <= r_ofc;
         olc_sh <= r_olc;
         ofr_sh <= r_ofr;
         olr_sh <= r_olr;
      end
   end

   assign first_hit = timing_enable & (arr_cnt == ofc_sh) & (rcr_cnt == ofr_sh);
   assign last_hit  = timing_enable & (arr_cnt == olc_sh) & (rcr_cnt == olr_sh);

   always_ff @(posedge pe_cap_clk or negedge pe_cap_rstn) begin
      if (!pe_cap_rstn) begin
         oc1ref          <= 1'b0;
         oc1_first_match <= 1'b0;
         oc1_last_match  <= 1'b0;
      end else if (pe_cap_logic_clr) begin
         oc1ref          <= 1'b0;
         oc1_first_match <= 1'b0;
         oc1_last_match  <= 1'b0;
      end else begin
         oc1ref          <= oc_next_ref(r_oc1m, oc1ref, first_hit, last_hit);
         oc1_first_match <= first_hit;
         oc1_last_match  <= last_hit;
      end
   end

   channel_deadtime_gen #(.DTW(DTW)) u_deadtime (
      .pe_cap_clk    (pe_cap_clk),
      .pe_cap_rstn   (pe_cap_rstn),
      .clr           (pe_cap_logic_clr),
      .timing_enable (timing_enable),
      .oc1ref        (oc1ref),
      .r_dtg         (r_dtg),
      .r_oc1ne       (r_oc1ne),
      .oc1p          (oc1p),
      .oc1n          (oc1n)
   );

endmodule
